// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data memory: access sizes, the response record
// and the alignment rule.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    // Reserved size counts as an error, together with any lane offset the size cannot start on.
    function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SIZE_BYTE: size_misaligned = 1'b0;
            SIZE_HALF: size_misaligned = lane[0];
            SIZE_WORD: size_misaligned = (lane != 2'b00);
            default:   size_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed little-endian byte or halfword out of a 32-bit word and sign- or
// zero-extends it. This block is purely combinational.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[8*lane +: 8];
        half_sel = lane[1] ? word[31:16] : word[15:0];
        data     = '0;
        case (size)
            SIZE_BYTE: data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SIZE_HALF: data = {{16{sign_ext & half_sel[15]}}, half_sel};
            SIZE_WORD: data = word;
            default:   data = '0;
        endcase
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// This is the handshaked MEM-stage data memory. It supports byte, half and word access and
// flags misaligned or out-of-range requests. Every request gets an in-order response after
// a fixed latency.
module data_memory_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DEPTH      = 1024,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W  = ADDR_W - 2;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]       mem [DEPTH];
    logic              ready_reg;
    rsp_t              stage_reg [RD_LATENCY];
    rsp_t              stage_next;

    logic [IDX_W-1:0]  word_idx;
    logic [1:0]        lane;
    logic [MEM_AW-1:0] mem_addr;
    logic              in_range;
    logic              req_err;
    logic              accept;
    logic              wr_en;
    logic [3:0]        byte_en;
    logic [31:0]       wr_lanes;
    logic [31:0]       mem_word;
    logic [31:0]       load_data;

    assign word_idx = req_addr[ADDR_W-1:2];
    assign lane     = req_addr[1:0];
    assign mem_addr = word_idx[MEM_AW-1:0];
    // The extra bit keeps the comparison exact when DEPTH fills the whole index space.
    assign in_range = ({1'b0, word_idx} < (IDX_W+1)'(DEPTH));
    assign req_err  = size_misaligned(req_size, lane) || !in_range;
    assign accept   = req_valid && ready_reg;
    assign wr_en    = accept && req_we && !req_err;

    // Store data is replicated across lanes so that each byte enable picks its own slice.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_en[gi] = (req_size == SIZE_WORD)
                              || (req_size == SIZE_HALF && lane[1] == (gi >= 2))
                              || (req_size == SIZE_BYTE && lane == 2'(gi));
            assign wr_lanes[8*gi +: 8] = (req_size == SIZE_WORD) ? req_wdata[8*gi +: 8] :
                                         (req_size == SIZE_HALF) ? req_wdata[8*(gi%2) +: 8] :
                                                                   req_wdata[7:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[mem_addr][8*b +: 8] <= wr_lanes[8*b +: 8];
                end
            end
        end
    end

    // Out-of-range requests never touch the array, so no X can reach the response.
    assign mem_word = in_range ? mem[mem_addr] : '0;

    load_align u_load_align (
        .word     (mem_word),
        .lane     (lane),
        .size     (req_size),
        .sign_ext (req_signed),
        .data     (load_data)
    );

    always_comb begin
        stage_next.valid = accept;
        stage_next.err   = accept && req_err;
        stage_next.rdata = (accept && !req_we && !req_err) ? load_data : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_reg <= 1'b0;
            for (int s = 0; s < RD_LATENCY; s++) begin
                stage_reg[s] <= '0;
            end
        end else begin
            ready_reg    <= 1'b1;
            stage_reg[0] <= stage_next;
            for (int s = 1; s < RD_LATENCY; s++) begin
                stage_reg[s] <= stage_reg[s-1];
            end
        end
    end

    assign req_ready = ready_reg;
    assign rsp_valid = stage_reg[RD_LATENCY-1].valid;
    assign rsp_err   = stage_reg[RD_LATENCY-1].err;
    assign rsp_rdata = stage_reg[RD_LATENCY-1].rdata;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl. Two instances share the request bus: one has
// latency 1 for function checks and the other has latency 3 for pipelining and reset flush.
module tb_data_memory_ctrl;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;

    logic        r1_ready, r1_valid, r1_err;
    logic [31:0] r1_rdata;
    logic        r3_ready, r3_valid, r3_err;
    logic [31:0] r3_rdata;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    data_memory_ctrl #(.ADDR_W(16), .DEPTH(1024), .RD_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(r1_ready),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(r1_valid), .rsp_rdata(r1_rdata), .rsp_err(r1_err)
    );

    data_memory_ctrl #(.ADDR_W(16), .DEPTH(1024), .RD_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(r3_ready),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(r3_valid), .rsp_rdata(r3_rdata), .rsp_err(r3_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [15:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    // One request, checked on the latency-1 instance right after its acceptance edge.
    task automatic xact1(input string tag, input logic we, input logic [1:0] size,
                         input logic sgn, input logic [15:0] addr, input logic [31:0] wdata,
                         input logic exp_err, input logic [31:0] exp_rdata);
        drive(we, size, sgn, addr, wdata);
        @(posedge clk);
        #1;
        check({tag, "/valid"}, r1_valid, 1);
        check({tag, "/err"}, r1_err, exp_err);
        check({tag, "/rdata"}, r1_rdata, exp_rdata);
        $display("xact %-10s we=%0b size=%0b sgn=%0b addr=%h wdata=%h -> err=%0b rdata=%h",
                 tag, we, size, sgn, addr, wdata, r1_err, r1_rdata);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst/ready1", r1_ready, 0);
        check("rst/ready3", r3_ready, 0);
        check("rst/valid1", r1_valid, 0);
        check("rst/err1", r1_err, 0);
        check("rst/rdata1", r1_rdata, 0);
        check("rst/valid3", r3_valid, 0);
        $display("xact reset held: ready1=%0b ready3=%0b", r1_ready, r3_ready);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel/ready1", r1_ready, 1);
        check("rel/ready3", r3_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        check("rel/novalid1", r1_valid, 0);
        check("rel/novalid3", r3_valid, 0);
        $display("xact reset released: ready1=%0b valid1=%0b", r1_ready, r1_valid);

        xact1("sw_0c", 1, SIZE_WORD, 0, 16'h000C, 32'h0000_03FF, 0, 32'h0);
        xact1("lw_0c", 0, SIZE_WORD, 0, 16'h000C, 32'h0, 0, 32'h0000_03FF);
        idle(1);
        #1;
        check("lw_0c/pulse", r1_valid, 0);

        xact1("sw_10", 1, SIZE_WORD, 0, 16'h0010, 32'h1122_3344, 0, 32'h0);
        xact1("sb_12", 1, SIZE_BYTE, 0, 16'h0012, 32'h0000_00AA, 0, 32'h0);
        xact1("lw_10", 0, SIZE_WORD, 1, 16'h0010, 32'h0, 0, 32'h11AA_3344);
        xact1("lb_12", 0, SIZE_BYTE, 1, 16'h0012, 32'h0, 0, 32'hFFFF_FFAA);
        xact1("lbu_12", 0, SIZE_BYTE, 0, 16'h0012, 32'h0, 0, 32'h0000_00AA);
        xact1("lh_12", 0, SIZE_HALF, 1, 16'h0012, 32'h0, 0, 32'h0000_11AA);
        xact1("lhu_10", 0, SIZE_HALF, 0, 16'h0010, 32'h0, 0, 32'h0000_3344);
        xact1("lbu_13", 0, SIZE_BYTE, 0, 16'h0013, 32'h0, 0, 32'h0000_0011);

        xact1("sw_14", 1, SIZE_WORD, 0, 16'h0014, 32'hCAFE_F00D, 0, 32'h0);
        xact1("sh_16", 1, SIZE_HALF, 0, 16'h0016, 32'h1234_8001, 0, 32'h0);
        xact1("lh_16", 0, SIZE_HALF, 1, 16'h0016, 32'h0, 0, 32'hFFFF_8001);
        xact1("sw_16_mis", 1, SIZE_WORD, 0, 16'h0016, 32'hDEAD_BEEF, 1, 32'h0);
        xact1("sb_oor", 1, SIZE_BYTE, 0, 16'h1014, 32'h0000_0055, 1, 32'h0);
        xact1("lw_14", 0, SIZE_WORD, 0, 16'h0014, 32'h0, 0, 32'h8001_F00D);
        xact1("lh_11_mis", 0, SIZE_HALF, 1, 16'h0011, 32'h0, 1, 32'h0);
        xact1("lw_0e_mis", 0, SIZE_WORD, 0, 16'h000E, 32'h0, 1, 32'h0);
        xact1("lw_oor", 0, SIZE_WORD, 0, 16'h1000, 32'h0, 1, 32'h0);
        xact1("l_rsvd", 0, 2'b11, 0, 16'h0000, 32'h0, 1, 32'h0);

        for (int i = 0; i < 4; i++) begin
            xact1("sw_seq", 1, SIZE_WORD, 0, 16'(i * 4), 32'(i + 1), 0, 32'h0);
        end
        idle(3);
        // The four loads are accepted on consecutive edges, and the latency-3 responses follow them back to back.
        for (int i = 0; i < 7; i++) begin
            if (i < 4) drive(0, SIZE_WORD, 0, 16'(i * 4), 32'h0);
            else begin
                @(negedge clk);
                req_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (i >= 2 && i < 6) begin
                check("lat3/valid", r3_valid, 1);
                check("lat3/rdata", r3_rdata, 32'(i - 1));
                check("lat3/err", r3_err, 0);
            end else begin
                check("lat3/idle", r3_valid, 0);
            end
            $display("xact lat3 cycle %0d: valid=%0b rdata=%h", i, r3_valid, r3_rdata);
        end

        drive(1, SIZE_WORD, 0, 16'h0020, 32'h5A5A_0001);
        @(posedge clk);
        drive(0, SIZE_WORD, 0, 16'h0000, 32'h0);
        @(posedge clk);
        drive(0, SIZE_WORD, 0, 16'h0004, 32'h0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst/ready3", r3_ready, 0);
        check("midrst/valid3", r3_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("midrst/flush", r3_valid, 0);
        end
        $display("xact reset mid-flight: ready3=%0b valid3=%0b", r3_ready, r3_valid);

        xact1("lw_20", 0, SIZE_WORD, 0, 16'h0020, 32'h0, 0, 32'h5A5A_0001);
        idle(2);
        #1;
        check("lw_20/valid3", r3_valid, 1);
        check("lw_20/rdata3", r3_rdata, 32'h5A5A_0001);
        $display("xact lw_20 lat3: valid=%0b rdata=%h", r3_valid, r3_rdata);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
